// File: rtl/tx_sched_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tx_sched_dispatch
// Purpose  : Latches a one-hot scheduling grant, streams one frame from the
//            selected crossbar FWFT FIFO as AXI-Stream, then pulses completion.
// Revision : 1.0 - initial release
// ============================================================================
module tx_sched_dispatch #(
    parameter int PORT_FIFO_PRI_NUM = 8,
    parameter int DATA_WIDTH        = 8,
    parameter int MAX_BEATS         = 1536
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic [PORT_FIFO_PRI_NUM:0]                  i_scheduing_rst,
    input  logic                                        i_scheduing_rst_vld,
    input  logic [PORT_FIFO_PRI_NUM:0]                  i_fifoc_empty,
    input  logic [(PORT_FIFO_PRI_NUM+1)*DATA_WIDTH-1:0] i_fifoc_data,
    input  logic [PORT_FIFO_PRI_NUM:0]                  i_fifoc_last,
    output logic [PORT_FIFO_PRI_NUM:0]                  o_fifoc_rden,
    output logic [DATA_WIDTH-1:0]                       o_tx_axis_data,
    output logic                                        o_tx_axis_valid,
    output logic                                        o_tx_axis_last,
    input  logic                                        i_tx_axis_ready,
    output logic                                        o_frame_done,
    output logic                                        o_busy,
    output logic [15:0]                                 o_grant_err_cnt
);

    localparam int c_NQ    = PORT_FIFO_PRI_NUM + 1;
    localparam int c_SEL_W = (c_NQ > 1) ? $clog2(c_NQ) : 1;
    localparam int c_CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_SEL_W-1:0]   r_sel_q, w_sel_d;
    logic [c_CNT_W-1:0]   r_beat_cnt_q, w_beat_cnt_d;
    logic [15:0]          r_err_cnt_q, w_err_cnt_d;

    logic                  w_grant_onehot;
    logic                  w_grant_nonempty;
    logic [c_SEL_W-1:0]    w_grant_idx;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_empty;
    logic                  w_head_last;
    logic                  w_pop;
    logic [15:0]           w_err_inc;

    // Grant decode: index of the set bit is only meaningful when exactly one-hot.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < c_NQ; i++) begin
            if (i_scheduing_rst[i]) begin
                w_grant_idx = c_SEL_W'(i);
            end
        end
        w_grant_onehot   = (i_scheduing_rst != '0) &&
                           ((i_scheduing_rst & (i_scheduing_rst - c_NQ'(1))) == '0);
        w_grant_nonempty = |(i_scheduing_rst & ~i_fifoc_empty);
    end

    always_comb begin
        w_head_data  = '0;
        w_head_empty = 1'b1;
        w_head_last  = 1'b0;
        for (int i = 0; i < c_NQ; i++) begin
            if (r_sel_q == c_SEL_W'(i)) begin
                w_head_data  = i_fifoc_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_head_empty = i_fifoc_empty[i];
                w_head_last  = i_fifoc_last[i];
            end
        end
    end

    assign w_err_inc = (r_err_cnt_q != 16'hFFFF) ? (r_err_cnt_q + 16'd1) : r_err_cnt_q;

    always_comb begin
        w_state_d       = r_state_q;
        w_sel_d         = r_sel_q;
        w_beat_cnt_d    = r_beat_cnt_q;
        w_err_cnt_d     = r_err_cnt_q;
        w_pop           = 1'b0;
        o_tx_axis_valid = 1'b0;
        o_tx_axis_data  = '0;
        o_tx_axis_last  = 1'b0;
        o_frame_done    = 1'b0;
        o_fifoc_rden    = '0;

        case (r_state_q)
            ST_IDLE: begin
                if (i_scheduing_rst_vld) begin
                    if (w_grant_onehot && w_grant_nonempty) begin
                        w_sel_d      = w_grant_idx;
                        w_beat_cnt_d = '0;
                        w_state_d    = ST_XFER;
                    end else begin
                        w_err_cnt_d = w_err_inc;
                    end
                end
            end
            ST_XFER: begin
                o_tx_axis_valid = ~w_head_empty;
                o_tx_axis_data  = w_head_data;
                // Truncation forces last on the final permitted beat.
                o_tx_axis_last  = w_head_last | (r_beat_cnt_q == c_LAST_CNT);
                if (o_tx_axis_valid && i_tx_axis_ready) begin
                    w_pop        = 1'b1;
                    w_beat_cnt_d = r_beat_cnt_q + c_CNT_W'(1);
                    if (w_head_last) begin
                        w_state_d = ST_DONE;
                    end else if (r_beat_cnt_q == c_LAST_CNT) begin
                        w_state_d = ST_DISCARD;
                    end
                end
                if (i_scheduing_rst_vld) begin
                    w_err_cnt_d = w_err_inc;
                end
            end
            ST_DISCARD: begin
                w_pop = ~w_head_empty;
                if (!w_head_empty && w_head_last) begin
                    w_state_d = ST_DONE;
                end
                if (i_scheduing_rst_vld) begin
                    w_err_cnt_d = w_err_inc;
                end
            end
            ST_DONE: begin
                o_frame_done = 1'b1;
                w_state_d    = ST_IDLE;
                if (i_scheduing_rst_vld) begin
                    w_err_cnt_d = w_err_inc;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Reset aborts immediately: no handshake or pop in the reset cycle.
        if (i_rst) begin
            w_pop           = 1'b0;
            o_tx_axis_valid = 1'b0;
            o_tx_axis_data  = '0;
            o_tx_axis_last  = 1'b0;
            o_frame_done    = 1'b0;
        end

        for (int i = 0; i < c_NQ; i++) begin
            if (w_pop && (r_sel_q == c_SEL_W'(i))) begin
                o_fifoc_rden[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q    <= ST_IDLE;
            r_sel_q      <= '0;
            r_beat_cnt_q <= '0;
            r_err_cnt_q  <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_sel_q      <= w_sel_d;
            r_beat_cnt_q <= w_beat_cnt_d;
            r_err_cnt_q  <= w_err_cnt_d;
        end
    end

    assign o_busy          = (r_state_q != ST_IDLE);
    assign o_grant_err_cnt = r_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_sched_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_sched_dispatch
// Purpose  : Scoreboard bench for tx_sched_dispatch with FWFT FIFO models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_sched_dispatch;

    localparam int c_NQ   = 9;
    localparam int c_DW   = 8;
    localparam int c_MAXB = 8;

    logic clk = 1'b0;
    always #2 clk = ~clk;

    logic                 rst_in = 1'b1;
    logic [c_NQ-1:0]      grant = '0;
    logic                 vld_in = 1'b0;
    logic                 ready = 1'b0;
    logic [c_NQ-1:0]      fifo_empty;
    logic [c_NQ*c_DW-1:0] fifo_data;
    logic [c_NQ-1:0]      fifo_last;
    logic [c_NQ-1:0]      rden;
    logic [c_DW-1:0]      axis_data;
    logic                 axis_valid;
    logic                 axis_last;
    logic                 frame_done;
    logic                 busy;
    logic [15:0]          err_cnt;

    tx_sched_dispatch #(
        .PORT_FIFO_PRI_NUM (c_NQ - 1),
        .DATA_WIDTH        (c_DW),
        .MAX_BEATS         (c_MAXB)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst_in),
        .i_scheduing_rst     (grant),
        .i_scheduing_rst_vld (vld_in),
        .i_fifoc_empty       (fifo_empty),
        .i_fifoc_data        (fifo_data),
        .i_fifoc_last        (fifo_last),
        .o_fifoc_rden        (rden),
        .o_tx_axis_data      (axis_data),
        .o_tx_axis_valid     (axis_valid),
        .o_tx_axis_last      (axis_last),
        .i_tx_axis_ready     (ready),
        .o_frame_done        (frame_done),
        .o_busy              (busy),
        .o_grant_err_cnt     (err_cnt)
    );

    // FWFT FIFO models: {last, data} entries, popped on rden.
    logic [8:0] mem [c_NQ][64];
    bit [15:0]  rp [c_NQ];
    bit [15:0]  wp [c_NQ];
    int         pops [c_NQ];
    int         underflow = 0;

    for (genvar g = 0; g < c_NQ; g++) begin : g_fifo
        assign fifo_empty[g]             = (rp[g] == wp[g]);
        assign fifo_data[g*c_DW +: c_DW] = mem[g][rp[g][5:0]][7:0];
        assign fifo_last[g]              = mem[g][rp[g][5:0]][8];
    end

    always @(posedge clk) begin
        for (int q = 0; q < c_NQ; q++) begin
            if (rden[q]) begin
                rp[q]   <= rp[q] + 16'd1;
                pops[q] <= pops[q] + 1;
                if (rp[q] == wp[q]) underflow <= underflow + 1;
            end
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q [$];
    logic [8:0] got;
    logic [8:0] expv;
    int         cyc = 0;
    int         cur_q = 0;
    int         beats, dones, holds;
    int         first_valid_cyc, last_beat_cyc, done_cyc;
    bit         prev_hold = 1'b0;
    logic [8:0] prev_beat = '0;

    task automatic push_frame(input int q, input int n, input logic [7:0] base, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            mem[q][wp[q][5:0]] = {(i == n - 1), base + 8'(i)};
            wp[q] = wp[q] + 16'd1;
            if (expect_out && i < c_MAXB)
                exp_q.push_back({(i == n - 1) || (i == c_MAXB - 1), base + 8'(i)});
        end
    endtask

    // One clock: drive after the edge, observe mid-cycle.
    task automatic tick(input bit rdy, input bit vld, input logic [c_NQ-1:0] g, input bit rst);
        logic [c_NQ-1:0] sel_oh;
        @(posedge clk);
        #1;
        ready  = rdy;
        vld_in = vld;
        grant  = g;
        rst_in = rst;
        @(negedge clk);
        cyc++;
        sel_oh = c_NQ'(1) << cur_q;
        checks++;
        if ($countones(rden) > 1) begin
            errors++;
            $display("FAIL rden_onehot: got %0h required at most one bit", rden);
        end
        if (prev_hold) begin
            checks++;
            if (!axis_valid || {axis_last, axis_data} !== prev_beat) begin
                errors++;
                $display("FAIL axis_hold: got v=%0b %0h required v=1 %0h", axis_valid, {axis_last, axis_data}, prev_beat);
            end
        end
        if (!busy) begin
            checks++;
            if ({axis_valid, axis_last, axis_data, rden, frame_done} !== '0) begin
                errors++;
                $display("FAIL idle_outputs: got v=%0b l=%0b d=%0h rden=%0h done=%0b required all 0",
                         axis_valid, axis_last, axis_data, rden, frame_done);
            end
        end
        if (axis_valid && rdy) begin
            got = {axis_last, axis_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got %0h required no beat", got);
            end else begin
                expv = exp_q.pop_front();
                if (got !== expv) begin
                    errors++;
                    $display("FAIL beat_data: got %0h required %0h", got, expv);
                end
            end
            checks++;
            if (rden !== sel_oh) begin
                errors++;
                $display("FAIL rden_on_beat: got %0h required %0h", rden, sel_oh);
            end
            beats++;
            last_beat_cyc = cyc;
        end else if (axis_valid) begin
            holds++;
            checks++;
            if (rden !== '0) begin
                errors++;
                $display("FAIL rden_stalled: got %0h required 0", rden);
            end
        end
        if (axis_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        prev_hold = axis_valid && !rdy;
        prev_beat = {axis_last, axis_data};
        if (frame_done) begin
            dones++;
            done_cyc = cyc;
        end
    endtask

    task automatic start_stats(input int q);
        cur_q = q; beats = 0; dones = 0; holds = 0;
        first_valid_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    endtask

    task automatic run_frame(input int q, input bit toggle, input int inj_i,
                             input logic [c_NQ-1:0] inj_g, output int grant_cyc);
        start_stats(q);
        tick(1'b1, 1'b1, c_NQ'(1) << q, 1'b0);
        grant_cyc = cyc;
        for (int i = 0; i < 64 && dones == 0; i++)
            tick(toggle ? (i % 2 == 0) : 1'b1, (i == inj_i), (i == inj_i) ? inj_g : '0, 1'b0);
        checks++;
        if (dones == 0) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_done required one within 64 cycles");
        end
        tick(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d required 1", dones);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (busy !== 1'b0 || err_cnt !== 16'd0 || axis_valid !== 1'b0 || rden !== '0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b err=%0d v=%0b rden=%0h done=%0b required all 0",
                     busy, err_cnt, axis_valid, rden, frame_done);
        end
    endtask

    task automatic check_frame(input string name, input int q, input int p0, input int exp_beats,
                               input int exp_pops, input int done_gap);
        checks++;
        if (beats !== exp_beats) begin
            errors++;
            $display("FAIL %s_beats: got %0d required %0d", name, beats, exp_beats);
        end
        checks++;
        if (pops[q] - p0 !== exp_pops) begin
            errors++;
            $display("FAIL %s_pops: got %0d required %0d", name, pops[q] - p0, exp_pops);
        end
        checks++;
        if (done_cyc !== last_beat_cyc + done_gap) begin
            errors++;
            $display("FAIL %s_done_timing: got cycle %0d required %0d", name, done_cyc, last_beat_cyc + done_gap);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_beats: got %0d left required 0", name, exp_q.size());
        end
    endtask

    task automatic test_basic_frame();
        int gc, p0;
        push_frame(2, 4, 8'h10, 1'b1);
        p0 = pops[2];
        run_frame(2, 1'b0, -1, '0, gc);
        checks++;
        if (first_valid_cyc !== gc + 1) begin
            errors++;
            $display("FAIL grant_latency: got cycle %0d required %0d", first_valid_cyc, gc + 1);
        end
        check_frame("basic", 2, p0, 4, 4, 1);
    endtask

    task automatic test_ready_toggle();
        int gc, p0;
        push_frame(2, 4, 8'h20, 1'b1);
        p0 = pops[2];
        run_frame(2, 1'b1, -1, '0, gc);
        checks++;
        if (holds == 0) begin
            errors++;
            $display("FAIL toggle_stalls: got %0d stalled cycles required > 0", holds);
        end
        check_frame("toggle", 2, p0, 4, 4, 1);
    endtask

    task automatic test_truncate();
        int gc, p0;
        push_frame(1, 12, 8'h40, 1'b1);
        p0 = pops[1];
        run_frame(1, 1'b0, -1, '0, gc);
        check_frame("truncate", 1, p0, c_MAXB, 12, 5);
        checks++;
        if (fifo_empty[1] !== 1'b1) begin
            errors++;
            $display("FAIL truncate_drain: got empty=%0b required 1", fifo_empty[1]);
        end
    endtask

    task automatic test_exact_max();
        int gc, p0;
        push_frame(3, c_MAXB, 8'h60, 1'b1);
        p0 = pops[3];
        run_frame(3, 1'b0, -1, '0, gc);
        check_frame("exact_max", 3, p0, c_MAXB, c_MAXB, 1);
    endtask

    task automatic test_bad_grants();
        int total0, total1;
        total0 = 0;
        for (int q = 0; q < c_NQ; q++) total0 += pops[q];
        start_stats(0);
        tick(1'b1, 1'b1, 9'h006, 1'b0);
        tick(1'b1, 1'b1, 9'h000, 1'b0);
        tick(1'b1, 1'b1, 9'h010, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (err_cnt !== 16'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_grants: got err=%0d busy=%0b required err=3 busy=0", err_cnt, busy);
        end
        total1 = 0;
        for (int q = 0; q < c_NQ; q++) total1 += pops[q];
        checks++;
        if (total1 !== total0 || beats !== 0) begin
            errors++;
            $display("FAIL bad_grants_activity: got pops=%0d beats=%0d required 0", total1 - total0, beats);
        end
    endtask

    task automatic test_back_to_back_grant();
        int gc, p0, p5;
        push_frame(5, 2, 8'hF0, 1'b0);
        push_frame(2, 4, 8'h80, 1'b1);
        p0 = pops[2];
        p5 = pops[5];
        run_frame(2, 1'b0, 1, 9'h020, gc);
        check_frame("overlap", 2, p0, 4, 4, 1);
        checks++;
        if (err_cnt !== 16'd4 || pops[5] !== p5) begin
            errors++;
            $display("FAIL overlap_grant: got err=%0d q5pops=%0d required err=4 q5pops=0", err_cnt, pops[5] - p5);
        end
    endtask

    task automatic test_reset_mid_frame();
        int gc, p6, p7;
        push_frame(6, 5, 8'hA0, 1'b1);
        p6 = pops[6];
        start_stats(6);
        tick(1'b1, 1'b1, 9'h040, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (beats !== 1) begin
            errors++;
            $display("FAIL rst_mid_first_beat: got %0d beats required 1", beats);
        end
        tick(1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (rden !== '0 || axis_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pop: got rden=%0h v=%0b required 0", rden, axis_valid);
        end
        tick(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if ({busy, axis_valid, axis_last, axis_data, rden, frame_done} !== '0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got busy=%0b v=%0b rden=%0h err=%0d required all 0",
                     busy, axis_valid, rden, err_cnt);
        end
        checks++;
        if (pops[6] - p6 !== 1) begin
            errors++;
            $display("FAIL rst_mid_pops: got %0d required 1", pops[6] - p6);
        end
        exp_q.delete();
        push_frame(7, 3, 8'hC0, 1'b1);
        p7 = pops[7];
        run_frame(7, 1'b0, -1, '0, gc);
        checks++;
        if (first_valid_cyc !== gc + 1) begin
            errors++;
            $display("FAIL post_rst_latency: got cycle %0d required %0d", first_valid_cyc, gc + 1);
        end
        check_frame("post_rst", 7, p7, 3, 3, 1);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_ready_toggle();
        test_truncate();
        test_exact_max();
        test_bad_grants();
        test_back_to_back_grant();
        test_reset_mid_frame();
        checks++;
        if (underflow !== 0) begin
            errors++;
            $display("FAIL fifo_underflow: got %0d pops of empty FIFOs required 0", underflow);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
